cva6_store_coalesce_buf: RTL and testbench

// - Parametrised, coalescing store buffer between the store unit and the data-cache/NoC write path.
// - Generalises the fixed write-buffer-depth / max-outstanding-stores settings into a runtime block: N entries, byte-merge, in-order issue with bounded outstanding writes.
// - Adds fence draining and a load-hazard lookup.

---
 rtl/cva6_wbuf_pkg.sv | 22 ++
 rtl/cva6_wbuf_match.sv | 43 ++++
 rtl/cva6_store_coalesce_buf.sv | 179 +++++++++++++++++
 tb/tb_cva6_store_coalesce_buf.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_wbuf_pkg.sv
// Shared types and width helpers for the coalescing store buffer.
//   wbuf_state_e : fence FSM states (RUN accepts stores, DRAIN waits for
//                  the buffer and the write path to empty, DONE pulses).
//   be_width     : byte-enable width for a data width.
//   off_width    : number of byte-offset bits dropped to form a word address.
package cva6_wbuf_pkg;

  typedef enum logic [1:0] {
    WB_RUN   = 2'd0,
    WB_DRAIN = 2'd1,
    WB_DONE  = 2'd2
  } wbuf_state_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/cva6_wbuf_match.sv
// Word-address match finder over all buffer entries.
//   valid_i    : per-entry valid bits
//   waddr_i    : per-entry word addresses
//   tail_i     : next free slot; tail_i-1 is the youngest entry
//   st_waddr_i : store word address -> st_hit_o / st_idx_o (youngest match)
//   ld_waddr_i : load word address  -> ld_hit_o (any valid match)
module cva6_wbuf_match #(
  parameter int DEPTH = 8,
  parameter int WA_W  = 61,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [DEPTH-1:0][WA_W-1:0] waddr_i,
  input  logic [PTR_W-1:0]           tail_i,
  input  logic [WA_W-1:0]            st_waddr_i,
  input  logic [WA_W-1:0]            ld_waddr_i,
  output logic                       st_hit_o,
  output logic [PTR_W-1:0]           st_idx_o,
  output logic                       ld_hit_o
);

  logic [PTR_W-1:0] idx;

  // Walk from the oldest slot (tail) to the youngest (tail-1); the last
  // match written is therefore the youngest one.
  always_comb begin
    st_hit_o = 1'b0;
    st_idx_o = '0;
    ld_hit_o = 1'b0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail_i + PTR_W'(k);
      if (valid_i[idx] && (waddr_i[idx] == st_waddr_i)) begin
        st_hit_o = 1'b1;
        st_idx_o = idx;
      end
      if (valid_i[idx] && (waddr_i[idx] == ld_waddr_i)) begin
        ld_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cva6_store_coalesce_buf.sv
// Coalescing store buffer between the store unit and the write path.
// Stores to the same word merge into the youngest matching entry while it
// is still unissued and cacheable; otherwise they allocate at the tail.
// Entries issue in order with a bound on unacknowledged writes, and are
// freed in order by mem_ack_i. A fence stops intake until everything is
// written and acknowledged, then pulses fence_done_o.
// Handshakes: st_* transfer on a cycle where st_valid_i & st_ready_o;
// mem_* transfer on a cycle where mem_valid_o & mem_ready_i. mem_addr_o
// holds while waiting; a waiting entry may still gain bytes from merges.
// Ports: clk_i/rst_i (sync active-high), st_* store input, fence_i /
// fence_done_o, mem_* write issue and ack, ld_addr_i/ld_hit_o hazard
// lookup, empty_o/full_o, dbg_state_o (current FSM state).
module cva6_store_coalesce_buf
  import cva6_wbuf_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic [DATA_W/8-1:0] st_be_i,
  input  logic                st_nc_i,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [1:0]          dbg_state_o
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int OFF_W = off_width(DATA_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic              issued;
    logic              nc;
    logic [WA_W-1:0]   waddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wbuf_entry_t;

  wbuf_entry_t      ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, iss_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d, outst_q, outst_d;
  wbuf_state_e      state_q;
  logic             fence_done_q;

  logic [DEPTH-1:0]           valid_vec;
  logic [DEPTH-1:0][WA_W-1:0] waddr_vec;
  logic [WA_W-1:0]            st_waddr, ld_waddr;
  logic                       st_hit, merge_ok, full;
  logic [PTR_W-1:0]           st_idx;
  logic                       issue_fire, st_fire, do_merge, do_alloc;
  wbuf_entry_t                iss_ent;
  logic                       unused_ok;

  assign st_waddr  = st_addr_i[ADDR_W-1:OFF_W];
  assign ld_waddr  = ld_addr_i[ADDR_W-1:OFF_W];
  assign unused_ok = ^{st_addr_i[OFF_W-1:0], ld_addr_i[OFF_W-1:0]};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      waddr_vec[i] = ent_q[i].waddr;
    end
  end

  cva6_wbuf_match #(.DEPTH(DEPTH), .WA_W(WA_W)) u_match (
    .valid_i    (valid_vec),
    .waddr_i    (waddr_vec),
    .tail_i     (tail_q),
    .st_waddr_i (st_waddr),
    .ld_waddr_i (ld_waddr),
    .st_hit_o   (st_hit),
    .st_idx_o   (st_idx),
    .ld_hit_o   (ld_hit_o)
  );

  assign full    = (count_q == CNT_W'(DEPTH));
  assign iss_ent = ent_q[iss_q];

  assign mem_valid_o = iss_ent.valid && !iss_ent.issued && (outst_q < CNT_W'(MAX_OUTST));
  assign mem_addr_o  = {iss_ent.waddr, {OFF_W{1'b0}}};
  assign mem_data_o  = iss_ent.data;
  assign mem_be_o    = iss_ent.be;
  assign issue_fire  = mem_valid_o && mem_ready_i;

  // An entry leaving for memory this cycle can no longer absorb bytes.
  assign merge_ok = st_hit && !ent_q[st_idx].issued && !ent_q[st_idx].nc && !st_nc_i &&
                    !(issue_fire && (st_idx == iss_q));

  // Registered full only: a same-cycle ack does not open a slot.
  assign st_ready_o = (state_q == WB_RUN) && (merge_ok || !full);
  assign st_fire    = st_valid_i && st_ready_o;
  assign do_merge   = st_fire && merge_ok;
  assign do_alloc   = st_fire && !merge_ok;

  assign count_d = count_q + CNT_W'(do_alloc) - CNT_W'(mem_ack_i);
  assign outst_d = outst_q + CNT_W'(issue_fire) - CNT_W'(mem_ack_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      iss_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
    end else begin
      if (issue_fire) begin
        ent_q[iss_q].issued <= 1'b1;
        iss_q               <= iss_q + 1'b1;
      end
      if (do_merge) begin
        for (int b = 0; b < BE_W; b++) begin
          if (st_be_i[b]) ent_q[st_idx].data[8*b +: 8] <= st_data_i[8*b +: 8];
        end
        ent_q[st_idx].be <= ent_q[st_idx].be | st_be_i;
      end
      if (do_alloc) begin
        ent_q[tail_q] <= '{valid: 1'b1, issued: 1'b0, nc: st_nc_i,
                           waddr: st_waddr, data: st_data_i, be: st_be_i};
        tail_q        <= tail_q + 1'b1;
      end
      if (mem_ack_i) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      count_q <= count_d;
      outst_q <= outst_d;
    end
  end

  // Drain completion looks at next-state counts so the pulse lands the
  // cycle after the final ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= WB_RUN;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state_q)
        WB_RUN:   if (fence_i) state_q <= WB_DRAIN;
        WB_DRAIN: if ((count_d == '0) && (outst_d == '0)) begin
                    state_q      <= WB_DONE;
                    fence_done_q <= 1'b1;
                  end
        WB_DONE:  state_q <= WB_RUN;
        default:  state_q <= WB_RUN;
      endcase
    end
  end

  assign fence_done_o = fence_done_q;
  assign empty_o      = (count_q == '0);
  assign full_o       = full;
  assign dbg_state_o  = state_q;

  ack_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_ack_i |-> (outst_q != '0));

endmodule

// File: tb/tb_cva6_store_coalesce_buf.sv
module tb_cva6_store_coalesce_buf;
  import cva6_wbuf_pkg::*;

  localparam int DEPTH     = 8;
  localparam int MAX_OUTST = 7;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        st_valid_i = 0, st_nc_i = 0, fence_i = 0, mem_ready_i = 0, mem_ack_i = 0;
  logic [63:0] st_addr_i = '0, st_data_i = '0, ld_addr_i = '0;
  logic [7:0]  st_be_i = '0;
  logic        st_ready_o, fence_done_o, mem_valid_o, ld_hit_o, empty_o, full_o;
  logic [63:0] mem_addr_o, mem_data_o;
  logic [7:0]  mem_be_o;
  logic [1:0]  dbg_state_o;

  cva6_store_coalesce_buf dut (
    .clk_i(clk_i), .rst_i(rst_i), .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_be_i(st_be_i), .st_nc_i(st_nc_i),
    .fence_i(fence_i), .fence_done_o(fence_done_o), .mem_valid_o(mem_valid_o),
    .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i), .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o),
    .empty_o(empty_o), .full_o(full_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard counters / logs ----------------
  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_ack_cyc = -1, last_pulse_cyc = -1, fence_pulses = 0;
  logic [63:0] hs_addr[$];
  logic [7:0]  hs_be[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: oldest-first queue of entries ----------------
  typedef struct {
    logic [60:0] waddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        nc;
    logic        issued;
  } m_ent_t;

  m_ent_t      mq[$];
  wbuf_state_e m_mode = WB_RUN;

  function automatic logic [63:0] bytemask(input logic [7:0] be);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  function automatic int m_issued();
    int n = 0;
    foreach (mq[i]) if (mq[i].issued) n++;
    return n;
  endfunction

  // Next to issue is the first unissued entry, allowed while under the cap.
  function automatic logic m_mem_valid();
    return (m_issued() < mq.size()) && (m_issued() < MAX_OUTST);
  endfunction

  function automatic int m_youngest(input logic [60:0] wa);
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].waddr == wa) return i;
    return -1;
  endfunction

  function automatic logic m_merge_ok();
    int yi = m_youngest(st_addr_i[63:3]);
    if (yi < 0) return 1'b0;
    if (mq[yi].issued || mq[yi].nc || st_nc_i) return 1'b0;
    if (m_mem_valid() && mem_ready_i && (yi == m_issued())) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_st_ready();
    return (m_mode == WB_RUN) && (m_merge_ok() || (mq.size() < DEPTH));
  endfunction

  function automatic logic m_ld_hit();
    foreach (mq[i]) if (mq[i].waddr == ld_addr_i[63:3]) return 1'b1;
    return 1'b0;
  endfunction

  // One process: compare on the falling edge, advance the model on the rising edge.
  initial begin
    m_ent_t ne;
    int     ni, yi;
    logic   fire, acc, mg;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        chk("st_ready", st_ready_o, m_st_ready());
        chk("mem_valid", mem_valid_o, m_mem_valid());
        if (m_mem_valid()) begin
          ni = m_issued();
          chk("mem_addr", mem_addr_o, {mq[ni].waddr, 3'b000});
          chk("mem_be", mem_be_o, mq[ni].be);
          chk("mem_data", mem_data_o & bytemask(mq[ni].be), mq[ni].data & bytemask(mq[ni].be));
        end
        chk("ld_hit", ld_hit_o, m_ld_hit());
        chk("empty", empty_o, mq.size() == 0);
        chk("full", full_o, mq.size() == DEPTH);
        chk("fence_done", fence_done_o, m_mode == WB_DONE);
        chk("state", dbg_state_o, m_mode);
        if (mem_valid_o && mem_ready_i) begin
          hs_addr.push_back(mem_addr_o);
          hs_be.push_back(mem_be_o);
        end
        if (fence_done_o) begin
          fence_pulses++;
          last_pulse_cyc = cyc;
        end
      end
      @(posedge clk_i);
      cyc++;
      if (rst_i) begin
        mq.delete();
        m_mode = WB_RUN;
      end else begin
        ni   = m_issued();
        fire = m_mem_valid() && mem_ready_i;
        acc  = st_valid_i && m_st_ready();
        mg   = m_merge_ok();
        yi   = m_youngest(st_addr_i[63:3]);
        if (fire) mq[ni].issued = 1'b1;
        if (acc && mg) begin
          mq[yi].data = (mq[yi].data & ~bytemask(st_be_i)) | (st_data_i & bytemask(st_be_i));
          mq[yi].be   = mq[yi].be | st_be_i;
        end else if (acc) begin
          ne = '{waddr: st_addr_i[63:3], data: st_data_i, be: st_be_i, nc: st_nc_i, issued: 1'b0};
          mq.push_back(ne);
        end
        if (mem_ack_i) void'(mq.pop_front());
        case (m_mode)
          WB_RUN:   if (fence_i) m_mode = WB_DRAIN;
          WB_DRAIN: if (mq.size() == 0) m_mode = WB_DONE;
          default:  m_mode = WB_RUN;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                          input logic nc);
    int   b = 0;
    logic done = 1'b0;
    st_valid_i = 1; st_addr_i = a; st_data_i = d; st_be_i = be; st_nc_i = nc;
    while (!done && b < 50) begin
      @(negedge clk_i);
      if (st_ready_o) done = 1'b1;
      @(posedge clk_i); #1;
      b++;
    end
    st_valid_i = 0; st_nc_i = 0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL store_accept: addr %h not accepted in %0d cycles (required acceptance)", a, b);
    end
  endtask

  task automatic do_ack();
    int b = 0;
    while (m_issued() == 0 && b < 50) begin step(1); b++; end
    if (m_issued() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL ack_wait: 0 writes outstanding after %0d cycles (required >0)", b);
    end else begin
      mem_ack_i = 1; last_ack_cyc = cyc;
      step(1);
      mem_ack_i = 0;
    end
  endtask

  task automatic wait_empty();
    int b = 0;
    @(negedge clk_i);
    while (!empty_o && b < 100) begin @(negedge clk_i); b++; end
    chk("drain_empty", empty_o, 1'b1);
    step(1);
  endtask

  task automatic wait_pulse(input int base);
    int b = 0;
    while (fence_pulses == base && b < 30) begin step(1); b++; end
    chk("fence_pulse_seen", fence_pulses - base, 1);
  endtask

  // ---------------- directed stimulus ----------------
  int base, pbase, fcyc;

  initial begin
    step(2);
    rst_i = 0;
    @(negedge clk_i);
    chk("rst_st_ready", st_ready_o, 1'b1);
    chk("rst_mem_valid", mem_valid_o, 1'b0);
    chk("rst_fence_done", fence_done_o, 1'b0);
    chk("rst_ld_hit", ld_hit_o, 1'b0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_state", dbg_state_o, WB_RUN);
    step(1);

    // Byte merge of two halves into one entry while the write path stalls.
    base = hs_addr.size();
    do_store(64'h1000, 64'h0000_0000_1122_3344, 8'h0F, 0);
    do_store(64'h1004, 64'hAABB_CCDD_0000_0000, 8'hF0, 0);
    @(negedge clk_i);
    chk("merge_valid", mem_valid_o, 1'b1);
    chk("merge_addr", mem_addr_o, 64'h1000);
    chk("merge_be", mem_be_o, 8'hFF);
    chk("merge_data", mem_data_o, 64'hAABB_CCDD_1122_3344);
    step(1);
    mem_ready_i = 1;
    step(3);
    mem_ready_i = 0;
    chk("merge_writes", hs_addr.size() - base, 1);
    do_ack();
    wait_empty();

    // Second store to a word that is issuing: no merge, two writes.
    base = hs_addr.size();
    mem_ready_i = 1;
    do_store(64'h2000, 64'h01, 8'h01, 0);
    do_store(64'h2000, 64'h0200, 8'h02, 0);
    step(3);
    chk("nomerge_writes", hs_addr.size() - base, 2);
    if (hs_addr.size() - base == 2) begin
      chk("nomerge_addr0", hs_addr[base], 64'h2000);
      chk("nomerge_addr1", hs_addr[base+1], 64'h2000);
      chk("nomerge_be0", hs_be[base], 8'h01);
      chk("nomerge_be1", hs_be[base+1], 8'h02);
    end
    do_ack(); do_ack();
    wait_empty();

    // Non-cacheable stores never merge; load hazard held until last ack.
    base = hs_addr.size();
    mem_ready_i = 0;
    ld_addr_i = 64'h3004;
    do_store(64'h3000, 64'h11, 8'h01, 1);
    do_store(64'h3000, 64'h22, 8'h01, 1);
    @(negedge clk_i);
    chk("nc_ld_hit", ld_hit_o, 1'b1);
    step(1);
    mem_ready_i = 1;
    step(4);
    mem_ready_i = 0;
    chk("nc_writes", hs_addr.size() - base, 2);
    do_ack();
    @(negedge clk_i);
    chk("nc_ld_hit_after_ack1", ld_hit_o, 1'b1);
    step(1);
    do_ack();
    @(negedge clk_i);
    chk("nc_ld_hit_after_ack2", ld_hit_o, 1'b0);
    step(1);
    ld_addr_i = 64'h0;
    wait_empty();

    // Outstanding cap: eight distinct words, no acks -> seven issued.
    base = hs_addr.size();
    mem_ready_i = 1;
    for (int i = 0; i < 8; i++) do_store(64'h4000 + 64'(8*i), 64'(i + 1), 8'hFF, 0);
    step(4);
    @(negedge clk_i);
    chk("cap_writes", hs_addr.size() - base, 7);
    chk("cap_held", mem_valid_o, 1'b0);
    step(1);
    do_ack();
    @(negedge clk_i);
    chk("cap_release_valid", mem_valid_o, 1'b1);
    chk("cap_release_addr", mem_addr_o, 64'h4038);
    step(1);
    @(negedge clk_i);
    chk("cap_writes_after_ack", hs_addr.size() - base, 8);
    step(1);
    for (int i = 0; i < 7; i++) do_ack();
    mem_ready_i = 0;
    wait_empty();

    // Full buffer: new word stalls, store to the youngest word merges.
    for (int i = 0; i < 8; i++) do_store(64'h5000 + 64'(8*i), 64'(i), 8'h01, 0);
    @(negedge clk_i);
    chk("full_set", full_o, 1'b1);
    step(1);
    st_valid_i = 1; st_addr_i = 64'h6000; st_data_i = 64'h99; st_be_i = 8'hFF;
    @(negedge clk_i);
    chk("full_new_ready", st_ready_o, 1'b0);
    step(1);
    st_addr_i = 64'h5038; st_data_i = 64'hFEED_0000; st_be_i = 8'h0C;
    @(negedge clk_i);
    chk("full_merge_ready", st_ready_o, 1'b1);
    step(1);
    st_valid_i = 0;
    mem_ready_i = 1;
    for (int i = 0; i < 8; i++) do_ack();
    mem_ready_i = 0;
    wait_empty();

    // Fence with three queued stores.
    for (int i = 0; i < 3; i++) do_store(64'h7000 + 64'(8*i), 64'hC0 + 64'(i), 8'h03, 0);
    pbase = fence_pulses;
    fence_i = 1;
    step(1);
    fence_i = 0;
    st_valid_i = 1; st_addr_i = 64'h7100; st_data_i = 64'h1; st_be_i = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("fence_stall", st_ready_o, 1'b0);
      step(1);
    end
    st_valid_i = 0;
    mem_ready_i = 1;
    for (int i = 0; i < 3; i++) do_ack();
    mem_ready_i = 0;
    wait_pulse(pbase);
    step(3);
    chk("fence_pulse_count", fence_pulses - pbase, 1);
    chk("fence_pulse_cycle", last_pulse_cyc, last_ack_cyc + 1);

    // Fence on an empty buffer: pulse two cycles after the request.
    pbase = fence_pulses;
    fence_i = 1; fcyc = cyc;
    step(1);
    fence_i = 0;
    wait_pulse(pbase);
    chk("fence_empty_cycle", last_pulse_cyc, fcyc + 2);
    step(2);

    // Reset in the middle of a drain.
    do_store(64'h8000, 64'h5, 8'h01, 0);
    do_store(64'h8008, 64'h6, 8'h01, 0);
    fence_i = 1;
    step(1);
    fence_i = 0;
    @(negedge clk_i);
    chk("mid_drain_state", dbg_state_o, WB_DRAIN);
    step(1);
    rst_i = 1;
    step(1);
    rst_i = 0;
    @(negedge clk_i);
    chk("post_rst_empty", empty_o, 1'b1);
    chk("post_rst_state", dbg_state_o, WB_RUN);
    chk("post_rst_ready", st_ready_o, 1'b1);
    chk("post_rst_mem_valid", mem_valid_o, 1'b0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (required completion)");
    $fatal(1);
  end

endmodule
